// File: rtl/ternary_sched.sv
// Round-robin arbiter and word sequencer that shares one 4-lane mod-3 engine between two
// polynomial samplers: fetch random word, issue to engine, stream packed trits, ack.
module ternary_sched #(
    parameter  int N_TRITS = 1400,
    localparam int WORDS   = N_TRITS / 4,
    localparam int CW      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    output logic [1:0]    ack,
    output logic [1:0]    gnt,
    input  logic          rnd_valid,
    output logic          rnd_ready,
    input  logic [31:0]   rnd_data,
    output logic          eng_start,
    output logic [31:0]   eng_data,
    input  logic          eng_done,
    input  logic [7:0]    eng_trits,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic [CW-1:0] out_idx,
    output logic          out_last
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

    logic [2:0]    state_q,    state_d;
    logic [1:0]    gnt_q,      gnt_d;
    logic          last_q,     last_d;
    logic [CW-1:0] count_q,    count_d;
    logic [31:0]   eng_data_q, eng_data_d;
    logic [7:0]    out_data_q, out_data_d;

    // last_q is the index of the most recently served requester; on a tie the other one wins.
    function automatic logic [1:0] pick_grant(input logic [1:0] r, input logic last);
        logic [1:0] g;
        if (r == 2'b11) begin
            g = last ? 2'b01 : 2'b10;
        end else begin
            g = r;
        end
        return g;
    endfunction

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        count_d    = count_q;
        eng_data_d = eng_data_q;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    gnt_d   = pick_grant(req, last_q);
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (rnd_valid) begin
                    eng_data_d = rnd_data;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    out_data_d = eng_trits;
                    state_d    = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (count_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        count_d = count_q + CW'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                last_d  = gnt_q[1];
                gnt_d   = 2'b00;
                count_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= 2'b00;
            last_q     <= 1'b1;
            count_q    <= '0;
            eng_data_q <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            count_q    <= count_d;
            eng_data_q <= eng_data_d;
            out_data_q <= out_data_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = (state_q == S_DONE) ? gnt_q : 2'b00;
    assign rnd_ready = (state_q == S_FETCH);
    assign eng_start = (state_q == S_ISSUE);
    assign eng_data  = eng_data_q;
    assign out_valid = (state_q == S_EMIT);
    assign out_data  = out_data_q;
    assign out_idx   = count_q;
    assign out_last  = (state_q == S_EMIT) && (count_q == LAST_IDX);

    logic trits_ok;
    assign trits_ok = (eng_trits[1:0] != 2'b11) && (eng_trits[3:2] != 2'b11) &&
                      (eng_trits[5:4] != 2'b11) && (eng_trits[7:6] != 2'b11);

    a_trits_legal: assert property (@(posedge clk) disable iff (rst) eng_done |-> trits_ok);
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));

endmodule

// File: tb/tb_ternary_sched.sv
// Directed bench for ternary_sched: a small (8-trit) instance for protocol scenarios and a
// full 1400-trit instance for the long randomized-stall run, sharing one set of models.
module tb_ternary_sched;

    localparam int NA  = 8;
    localparam int NB  = 1400;
    localparam int WA  = NA / 4;
    localparam int WB  = NB / 4;
    localparam int CWA = (WA > 1) ? $clog2(WA) : 1;
    localparam int CWB = (WB > 1) ? $clog2(WB) : 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic        sel   = 1'b0;
    logic [1:0]  req   = 2'b00;
    logic        rnd_valid;
    logic [31:0] rnd_data;
    logic        eng_done;
    logic [7:0]  eng_trits;
    logic        sink_rdy;
    logic        sink_hold = 1'b0;
    logic        out_ready;
    assign out_ready = sink_rdy & ~sink_hold;

    logic [1:0] ack_a, gnt_a, ack_b, gnt_b;
    logic rnd_ready_a, eng_start_a, out_valid_a, out_last_a;
    logic rnd_ready_b, eng_start_b, out_valid_b, out_last_b;
    logic [31:0] eng_data_a, eng_data_b;
    logic [7:0] out_data_a, out_data_b;
    logic [CWA-1:0] out_idx_a;
    logic [CWB-1:0] out_idx_b;

    ternary_sched #(.N_TRITS(NA)) dut_a (
        .clk(clk), .rst(rst_a), .req(req), .ack(ack_a), .gnt(gnt_a),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready_a), .rnd_data(rnd_data),
        .eng_start(eng_start_a), .eng_data(eng_data_a), .eng_done(eng_done), .eng_trits(eng_trits),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_idx(out_idx_a), .out_last(out_last_a)
    );

    ternary_sched #(.N_TRITS(NB)) dut_b (
        .clk(clk), .rst(rst_b), .req(req), .ack(ack_b), .gnt(gnt_b),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready_b), .rnd_data(rnd_data),
        .eng_start(eng_start_b), .eng_data(eng_data_b), .eng_done(eng_done), .eng_trits(eng_trits),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_idx(out_idx_b), .out_last(out_last_b)
    );

    logic [1:0] ack, gnt;
    logic rnd_ready, eng_start, out_valid, out_last;
    logic [31:0] eng_data;
    logic [7:0] out_data;
    logic [8:0] out_idx;
    assign ack       = sel ? ack_b       : ack_a;
    assign gnt       = sel ? gnt_b       : gnt_a;
    assign rnd_ready = sel ? rnd_ready_b : rnd_ready_a;
    assign eng_start = sel ? eng_start_b : eng_start_a;
    assign out_valid = sel ? out_valid_b : out_valid_a;
    assign out_last  = sel ? out_last_b  : out_last_a;
    assign eng_data  = sel ? eng_data_b  : eng_data_a;
    assign out_data  = sel ? out_data_b  : out_data_a;
    assign out_idx   = sel ? 9'(out_idx_b) : 9'(out_idx_a);

    int checks = 0;
    int failures = 0;

    function automatic logic [7:0] trits_of(input logic [31:0] w);
        logic [7:0] t;
        t = '0;
        for (int i = 0; i < 4; i++) t[2*i +: 2] = 2'(w[8*i +: 8] % 8'd3);
        return t;
    endfunction

    // Engine model: latches the word on eng_start, answers after eng_lat cycles.
    int eng_lat = 1;
    bit eng_rand = 1'b0;
    int eng_starts;
    initial begin : engine
        int pend;
        logic [31:0] held;
        pend = 0; held = '0; eng_starts = 0;
        eng_done = 1'b0; eng_trits = 8'h00;
        forever begin
            @(posedge clk); #1;
            eng_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    eng_done  = 1'b1;
                    eng_trits = trits_of(held);
                end
            end
            @(negedge clk);
            if (eng_start === 1'b1) begin
                eng_starts++;
                held = eng_data;
                pend = eng_rand ? int'($urandom_range(1, 4)) : eng_lat;
            end
        end
    end

    // RNG model: offers rnd_mem[rnd_rp] with optional idle gap after each accepted word.
    logic [31:0] rnd_mem [0:1023];
    int rnd_wp = 0;
    int rnd_gap = 0;
    bit rnd_rand = 1'b0;
    int rnd_rp;
    initial begin : rng
        int gap;
        gap = 0; rnd_rp = 0;
        rnd_valid = 1'b0; rnd_data = '0;
        forever begin
            @(posedge clk); #1;
            if (gap > 0) begin
                gap--;
                rnd_valid = 1'b0;
            end else if (rnd_rp < rnd_wp) begin
                rnd_valid = 1'b1;
                rnd_data  = rnd_mem[rnd_rp];
            end else begin
                rnd_valid = 1'b0;
            end
            @(negedge clk);
            if (rnd_valid && rnd_ready === 1'b1) begin
                rnd_rp++;
                gap = rnd_rand ? int'($urandom_range(0, 3)) : rnd_gap;
            end
        end
    end

    // Sink model: records every accepted beat.
    logic [7:0] bd [0:1023];
    int         bi [0:1023];
    logic       bl [0:1023];
    int nbeats;
    bit sink_rand = 1'b0;
    initial begin : sink
        nbeats = 0;
        sink_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            sink_rdy = sink_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                bd[nbeats] = out_data;
                bi[nbeats] = int'(out_idx);
                bl[nbeats] = out_last;
                nbeats++;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [31:0] w);
        rnd_mem[rnd_wp] = w;
        rnd_wp++;
    endtask

    task automatic wait_ack(input int budget, output logic [1:0] seen, output logic [1:0] gnt_at);
        seen = 2'b00; gnt_at = 2'b00;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (ack !== 2'b00) begin
                seen = ack; gnt_at = gnt;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1; req = 2'b00;
        repeat (3) tick();
        checks++;
        if ({ack, gnt, rnd_ready, eng_start, out_valid, out_last} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctrl got=%b required=0", {ack, gnt, rnd_ready, eng_start, out_valid, out_last});
        end
        checks++;
        if (eng_data !== 32'h0 || out_data !== 8'h0 || out_idx !== 9'h0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%0d required=0/0/0", eng_data, out_data, out_idx);
        end
        req = 2'b01;
        tick();
        checks++;
        if (gnt !== 2'b00) begin
            failures++; $display("FAIL reset_req_held got=%b required=00", gnt);
        end
        req = 2'b00; rst_a = 1'b0;
        repeat (2) tick();
        checks++;
        if (gnt !== 2'b00 || rnd_ready !== 1'b0) begin
            failures++; $display("FAIL idle_noreq gnt=%b rdy=%b required=00/0", gnt, rnd_ready);
        end
    endtask

    task automatic test_basic();
        int b0;
        logic [1:0] a;
        eng_lat = 1; b0 = nbeats; a = 2'b00;
        push(32'h04030201); push(32'h05050505);
        req = 2'b01;
        tick();
        for (int c = 0; c < 40 && a == 2'b00; c++) begin
            checks++;
            if (gnt !== 2'b01) begin
                failures++; $display("FAIL basic_gnt cycle=%0d got=%b required=01", c, gnt);
            end
            if (ack !== 2'b00) a = ack;
            else tick();
        end
        req = 2'b00;
        checks++;
        if (a !== 2'b01) begin failures++; $display("FAIL basic_ack got=%b required=01", a); end
        tick();
        checks++;
        if (ack !== 2'b00 || gnt !== 2'b00) begin
            failures++; $display("FAIL basic_ack_pulse ack=%b gnt=%b required=00/00", ack, gnt);
        end
        checks++;
        if (nbeats - b0 !== 2) begin
            failures++; $display("FAIL basic_beats got=%0d required=2", nbeats - b0);
        end else begin
            checks++;
            if (bd[b0] !== 8'h49 || bi[b0] !== 0 || bl[b0] !== 1'b0) begin
                failures++; $display("FAIL basic_beat0 got=%h/%0d/%b required=49/0/0", bd[b0], bi[b0], bl[b0]);
            end
            checks++;
            if (bd[b0+1] !== 8'hAA || bi[b0+1] !== 1 || bl[b0+1] !== 1'b1) begin
                failures++; $display("FAIL basic_beat1 got=%h/%0d/%b required=AA/1/1", bd[b0+1], bi[b0+1], bl[b0+1]);
            end
        end
    endtask

    task automatic test_rr();
        logic [1:0] exp_g [0:4];
        logic [1:0] a, g;
        logic [31:0] w;
        int b0, w0;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        rst_a = 1'b1; tick(); tick(); rst_a = 1'b0;
        b0 = nbeats; w0 = rnd_wp;
        for (int i = 0; i < 10; i++) begin
            w = {8'(i * 7 + 1), 8'(i * 5 + 2), 8'(i * 3), 8'(255 - i)};
            push(w);
        end
        req = 2'b11;
        for (int k = 0; k < 5; k++) begin
            wait_ack(60, a, g);
            if (k == 4) req = 2'b00;
            checks++;
            if (a !== exp_g[k] || g !== exp_g[k]) begin
                failures++; $display("FAIL rr_grant%0d ack=%b gnt=%b required=%b", k, a, g, exp_g[k]);
            end
        end
        checks++;
        if (nbeats - b0 !== 10) begin
            failures++; $display("FAIL rr_beats got=%0d required=10", nbeats - b0);
        end else begin
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (bd[b0+k] !== trits_of(rnd_mem[w0+k]) || bi[b0+k] !== (k % 2)) begin
                    failures++; $display("FAIL rr_beat%0d got=%h/%0d required=%h/%0d", k, bd[b0+k], bi[b0+k], trits_of(rnd_mem[w0+k]), k % 2);
                end
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        int b0;
        logic [1:0] a, g;
        b0 = nbeats; sink_hold = 1'b1;
        push(32'h0A141E28); push(32'hFFFFFFFF);
        req = 2'b01;
        for (int c = 0; c < 40 && out_valid !== 1'b1; c++) tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h61 || out_idx !== 9'd0 || out_last !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d got=%b/%h/%0d/%b required=1/61/0/0", k, out_valid, out_data, out_idx, out_last);
            end
            checks++;
            if (rnd_ready !== 1'b0 || eng_start !== 1'b0) begin
                failures++; $display("FAIL bp_quiet%0d rdy=%b start=%b required=0/0", k, rnd_ready, eng_start);
            end
            tick();
        end
        sink_hold = 1'b0;
        wait_ack(60, a, g);
        req = 2'b00;
        checks++;
        if (a !== 2'b01) begin failures++; $display("FAIL bp_ack got=%b required=01", a); end
        checks++;
        if (nbeats - b0 !== 2 || bd[b0] !== 8'h61 || bd[b0+1] !== 8'h00 || bl[b0+1] !== 1'b1) begin
            failures++; $display("FAIL bp_beats n=%0d d=%h/%h required=2 61/00", nbeats - b0, bd[b0], bd[b0+1]);
        end
        tick();
    endtask

    task automatic test_latency();
        int b0, s0;
        logic [1:0] a, g;
        eng_lat = 7; rnd_gap = 3;
        b0 = nbeats; s0 = eng_starts;
        push(32'h80C0E0F0); push(32'h11223344);
        req = 2'b10;
        wait_ack(200, a, g);
        req = 2'b00;
        checks++;
        if (a !== 2'b10 || g !== 2'b10) begin
            failures++; $display("FAIL lat_ack ack=%b gnt=%b required=10", a, g);
        end
        checks++;
        if (eng_starts - s0 !== 2) begin
            failures++; $display("FAIL lat_starts got=%0d required=2", eng_starts - s0);
        end
        checks++;
        if (nbeats - b0 !== 2 || bd[b0] !== 8'h88 || bi[b0] !== 0 || bd[b0+1] !== 8'h92 || bi[b0+1] !== 1) begin
            failures++;
            $display("FAIL lat_beats n=%0d got=%h@%0d %h@%0d required=88@0 92@1", nbeats - b0, bd[b0], bi[b0], bd[b0+1], bi[b0+1]);
        end
        eng_lat = 1; rnd_gap = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        int b0, ns;
        logic [1:0] a, g;
        eng_lat = 6; b0 = nbeats; ns = 0;
        push(32'h04070A0D); push(32'h0F0F0F0F);
        req = 2'b01;
        for (int c = 0; c < 100 && ns < 2; c++) begin
            tick();
            if (eng_start === 1'b1) ns++;
        end
        tick();
        checks++;
        if (gnt !== 2'b01 || out_valid !== 1'b0 || rnd_ready !== 1'b0 || eng_start !== 1'b0) begin
            failures++; $display("FAIL rm_in_wait gnt=%b v=%b r=%b s=%b required=01/0/0/0", gnt, out_valid, rnd_ready, eng_start);
        end
        rst_a = 1'b1; req = 2'b00;
        tick();
        checks++;
        if ({ack, gnt, rnd_ready, eng_start, out_valid, out_last} !== 8'h00 ||
            eng_data !== 32'h0 || out_data !== 8'h0 || out_idx !== 9'h0) begin
            failures++; $display("FAIL rm_reset got=%b %h %h %0d required=0", {ack, gnt, rnd_ready, eng_start, out_valid, out_last}, eng_data, out_data, out_idx);
        end
        rst_a = 1'b0; eng_lat = 1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (ack !== 2'b00 || out_valid !== 1'b0 || gnt !== 2'b00) begin
                failures++; $display("FAIL rm_quiet%0d ack=%b v=%b gnt=%b required=00/0/00", c, ack, out_valid, gnt);
            end
        end
        checks++;
        if (nbeats - b0 !== 1 || bd[b0] !== 8'h55) begin
            failures++; $display("FAIL rm_partial n=%0d d=%h required=1 55", nbeats - b0, bd[b0]);
        end
        push(32'h02020202); push(32'h01000201);
        req = 2'b01;
        wait_ack(60, a, g);
        req = 2'b00;
        checks++;
        if (a !== 2'b01) begin failures++; $display("FAIL rm_ack got=%b required=01", a); end
        checks++;
        if (nbeats - b0 !== 3 || bd[b0+1] !== 8'hAA || bi[b0+1] !== 0 ||
            bd[b0+2] !== 8'h49 || bi[b0+2] !== 1 || bl[b0+2] !== 1'b1) begin
            failures++; $display("FAIL rm_restart n=%0d got=%h@%0d %h@%0d required=AA@0 49@1", nbeats - b0, bd[b0+1], bi[b0+1], bd[b0+2], bi[b0+2]);
        end
        tick();
    endtask

    task automatic test_long();
        int b0, w0;
        logic [1:0] a, g;
        logic exp_last;
        rst_a = 1'b1; sel = 1'b1; rst_b = 1'b1;
        tick(); tick();
        rst_b = 1'b0;
        tick();
        eng_rand = 1'b1; rnd_rand = 1'b1; sink_rand = 1'b1;
        b0 = nbeats; w0 = rnd_wp;
        for (int i = 0; i < WB; i++) push($urandom);
        req = 2'b01;
        wait_ack(20000, a, g);
        req = 2'b00;
        checks++;
        if (a !== 2'b01) begin failures++; $display("FAIL long_ack got=%b required=01", a); end
        checks++;
        if (nbeats - b0 !== WB) begin
            failures++; $display("FAIL long_beats got=%0d required=%0d", nbeats - b0, WB);
        end else begin
            for (int k = 0; k < WB; k++) begin
                exp_last = (k == WB - 1);
                checks++;
                if (bd[b0+k] !== trits_of(rnd_mem[w0+k]) || bi[b0+k] !== k || bl[b0+k] !== exp_last) begin
                    failures++;
                    $display("FAIL long_beat%0d got=%h/%0d/%b required=%h/%0d/%b", k, bd[b0+k], bi[b0+k], bl[b0+k], trits_of(rnd_mem[w0+k]), k, exp_last);
                end
            end
        end
        eng_rand = 1'b0; rnd_rand = 1'b0; sink_rand = 1'b0;
    endtask

    initial begin : main
        test_reset();
        test_basic();
        test_rr();
        test_backpressure();
        test_latency();
        test_reset_mid();
        test_long();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
